load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage downstream of the multicycle control unit; executes one RISC-V load or store per request against a word-wide data memory.
- Performs address alignment, byte/halfword extraction with sign/zero extension, and read-modify-write for sb/sh.
- Raises a done pulse when the access completes, so the control FSM can leave its memory states on completion instead of after fixed cycle counts.

Parameters:
- MEM_LAT, 1, read latency of data memory in cycles (>=1); mem_rdata is valid after mem_addr has been held MEM_LAT cycles.
- XLEN, 32, data/address width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  access request; accepted only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  input  XLEN  byte address (ALU result).
- req_wdata  input  XLEN  store data (register B).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; misaligned access or illegal funct3.
- rdata  output  XLEN  extended load result; valid from done, held until the next load completes.
- mem_addr  output  XLEN  word address {addr[31:2],2'b00}.
- mem_wr  output  1  memory write strobe (single cycle).
- mem_wdata  output  XLEN  full word to write.
- mem_rdata  input  XLEN  memory read word.

Behaviour:
- Reset: state IDLE. busy, done, err, rdata, mem_addr, mem_wr, mem_wdata all 0. Latency counter cleared.
- Reset mid-operation: mem_wr drops immediately and any in-flight access is abandoned with no done.
- Acceptance: in IDLE with req_valid=1, capture req_we, req_funct3, req_addr, req_wdata at the clock edge (cycle 0). Inputs may change afterwards. req_valid while busy is ignored, not queued.
- Checks are decoded at acceptance:
  - misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
  - illegal funct3: loads 011/110/111; stores >=011.
  - Either condition: next state ERR.
- States:
  - IDLE: waits for req_valid.
  - RD: mem_addr held, mem_wr=0, counter counts MEM_LAT cycles; mem_rdata sampled on the last RD cycle. Load -> DONE; sb/sh -> WR.
  - WR: mem_wr=1 for exactly one cycle with mem_wdata. Then -> DONE.
  - DONE: done=1 for one cycle. Then -> IDLE.
  - ERR: done=1 and err=1 for one cycle, no memory write. Then -> IDLE.
- Latency, counted in cycles after acceptance:
  - load: RD in cycles 1..MEM_LAT, done in cycle MEM_LAT+1.
  - sw: WR in cycle 1 (no read), done in cycle 2.
  - sb/sh: RD in cycles 1..MEM_LAT, WR in MEM_LAT+1, done in MEM_LAT+2.
  - error: done+err in cycle 1.
- Load extraction, little-endian:
  - byte lane = addr[1:0]; halfword lane = addr[1].
  - lb/lh sign-extend to XLEN; lbu/lhu zero-extend; lw passes the word through.
- Store merge:
  - sb replaces byte lane addr[1:0] of the read word with wdata[7:0].
  - sh replaces halfword lane addr[1] with wdata[15:0].
  - Other bytes are preserved exactly.
- rdata updates only on successful loads; stores and errors leave it unchanged. err=0 whenever done follows a successful access.
- Back-to-back: a new request is accepted on the cycle after DONE/ERR (IDLE), so the minimum spacing is 1 idle cycle. Accepted requests never overlap.

Test Plan:
- Reset then lw: mem[0x10]=0xDEADBEEF, MEM_LAT=1, req lw addr 0x10 -> mem_addr=0x10, done in cycle 2, rdata=0xDEADBEEF, err=0, mem_wr never 1.
- Byte/half loads from word 0x80F07F01 at 0x20: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80F0; lhu 0x20 -> 0x00007F01; lb 0x20 -> 0x00000001.
- sb 0x25 wdata 0x000000AA over 0x11223344 -> one mem_wr cycle at 0x24 with 0x1122AA44, done in cycle MEM_LAT+2. Repeat with MEM_LAT=3 -> RD lasts 3 cycles, done in cycle 5.
- sh 0x2A wdata 0x0000BEEF over 0x11223344 -> writes 0xBEEF3344. sw 0x30 wdata 0xCAFEF00D -> mem_wr in cycle 1, no RD, done in cycle 2.
- Errors: lw 0x41, sh 0x43, load funct3=011 -> done+err in cycle 1, mem_wr stays 0, memory contents and rdata unchanged.
- Assert rst during WR of an sb -> mem_wr falls asynchronously, busy=0, no done. A req_valid pulse while busy is dropped (only one done observed).

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request and data-memory bus between the control FSM, the LSU and memory.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            busy;
  logic            done;
  logic            err;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one RISC-V load/store per request against word-wide memory.
// Sub-word stores are read-modify-write; done pulses when the access completes.
module load_store_unit #(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  logic            illegal, misaligned;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val, merged;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    // Stores only define funct3 000..010; loads additionally allow the unsigned 100/101.
    illegal    = bus.req_we ? (bus.req_funct3 >= 3'b011)
                            : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
    misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);

    byte_sel = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (funct3_q == 3'b000) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          funct3_d   = bus.req_funct3;
          lane_d     = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          mem_addr_d = {bus.req_addr[XLEN-1:2], 2'b00};
          cnt_d      = '0;
          if (illegal || misaligned) begin
            state_d = S_ERR;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          if (we_q) begin
            mem_wdata_d = merged;
            state_d     = S_WR;
          end else begin
            rdata_d = load_val;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // mem_wr decodes straight from state so an async reset kills the strobe at once.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE) || (state_q == S_ERR);
    bus.err       = (state_q == S_ERR);
    bus.mem_wr    = (state_q == S_WR);
    bus.rdata     = rdata_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed checks of load_store_unit at MEM_LAT 1 and 3.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  load_store_unit_if #(.XLEN(32)) bus1 ();
  load_store_unit_if #(.XLEN(32)) bus3 ();

  load_store_unit #(.MEM_LAT(1), .XLEN(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  load_store_unit #(.MEM_LAT(3), .XLEN(32)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus1.req_valid  = req_valid & ~sel;
  assign bus3.req_valid  = req_valid & sel;
  assign bus1.req_we     = req_we;
  assign bus3.req_we     = req_we;
  assign bus1.req_funct3 = req_funct3;
  assign bus3.req_funct3 = req_funct3;
  assign bus1.req_addr   = req_addr;
  assign bus3.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus3.req_wdata  = req_wdata;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  assign bus1.mem_rdata = mem[bus1.mem_addr[7:2]];
  assign bus3.mem_rdata = mem[bus3.mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    if (bus1.mem_wr) mem[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
    if (bus3.mem_wr) mem[bus3.mem_addr[7:2]] <= bus3.mem_wdata;
  end

  logic        o_busy, o_done, o_err, o_mem_wr;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  assign o_busy      = sel ? bus3.busy      : bus1.busy;
  assign o_done      = sel ? bus3.done      : bus1.done;
  assign o_err       = sel ? bus3.err       : bus1.err;
  assign o_mem_wr    = sel ? bus3.mem_wr    : bus1.mem_wr;
  assign o_rdata     = sel ? bus3.rdata     : bus1.rdata;
  assign o_mem_addr  = sel ? bus3.mem_addr  : bus1.mem_addr;
  assign o_mem_wdata = sel ? bus3.mem_wdata : bus1.mem_wdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_set(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  int          r_done_cyc, r_wr_cyc, r_rd_cyc, r_wr_cnt;
  logic        r_err;
  logic [31:0] r_wr_addr, r_wr_data, r_mem_addr;

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    r_done_cyc = 0; r_wr_cyc = 0; r_rd_cyc = 0; r_wr_cnt = 0;
    r_err = 1'bx; r_wr_addr = '0; r_wr_data = '0; r_mem_addr = '0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_mem_wr) begin
        r_wr_cyc = k; r_wr_cnt++; r_wr_addr = o_mem_addr; r_wr_data = o_mem_wdata;
      end else if (o_busy && !o_done) begin
        r_rd_cyc++;
      end
      if (o_done) begin
        r_done_cyc = k; r_err = o_err; r_mem_addr = o_mem_addr;
        break;
      end
    end
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rd_before);
    run_req(we, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_done_cyc"}, r_done_cyc, 1);
    chk({tag, "_err"}, {31'b0, r_err}, 1);
    chk({tag, "_wr_cnt"}, r_wr_cnt, 0);
    chk({tag, "_rdata"}, o_rdata, rd_before);
  endtask

  int          ndone;
  logic [31:0] seen_rdata;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus1.busy}, 0);
    chk("rst_done", {31'b0, bus1.done}, 0);
    chk("rst_err", {31'b0, bus1.err}, 0);
    chk("rst_rdata", bus1.rdata, 0);
    chk("rst_mem_addr", bus1.mem_addr, 0);
    chk("rst_mem_wr", {31'b0, bus1.mem_wr}, 0);
    chk("rst_mem_wdata", bus1.mem_wdata, 0);
    rst = 1'b0;

    mem_set(6'd4,  32'hDEAD_BEEF);
    mem_set(6'd8,  32'h80F0_7F01);
    mem_set(6'd9,  32'h1122_3344);
    mem_set(6'd10, 32'h1122_3344);
    mem_set(6'd12, 32'h0000_0000);
    mem_set(6'd16, 32'h5566_7788);

    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_done_cyc", r_done_cyc, 2);
    chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("lw_err", {31'b0, r_err}, 0);
    chk("lw_wr_cnt", r_wr_cnt, 0);
    chk("lw_mem_addr", r_mem_addr, 32'h10);

    run_req(1'b0, 3'b000, 32'h23, 32'h0);
    chk("lb_23", o_rdata, 32'hFFFF_FF80);
    run_req(1'b0, 3'b100, 32'h23, 32'h0);
    chk("lbu_23", o_rdata, 32'h0000_0080);
    run_req(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_22", o_rdata, 32'hFFFF_80F0);
    run_req(1'b0, 3'b101, 32'h20, 32'h0);
    chk("lhu_20", o_rdata, 32'h0000_7F01);
    run_req(1'b0, 3'b000, 32'h20, 32'h0);
    chk("lb_20", o_rdata, 32'h0000_0001);
    chk("lb_20_done_cyc", r_done_cyc, 2);

    run_req(1'b1, 3'b000, 32'h25, 32'h0000_00AA);
    chk("sb_wr_cnt", r_wr_cnt, 1);
    chk("sb_wr_cyc", r_wr_cyc, 2);
    chk("sb_wr_addr", r_wr_addr, 32'h24);
    chk("sb_wr_data", r_wr_data, 32'h1122_AA44);
    chk("sb_done_cyc", r_done_cyc, 3);
    chk("sb_mem", mem[9], 32'h1122_AA44);
    chk("sb_rdata_kept", o_rdata, 32'h0000_0001);

    run_req(1'b1, 3'b001, 32'h2A, 32'h0000_BEEF);
    chk("sh_wr_data", r_wr_data, 32'hBEEF_3344);
    chk("sh_done_cyc", r_done_cyc, 3);
    chk("sh_mem", mem[10], 32'hBEEF_3344);

    run_req(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
    chk("sw_wr_cyc", r_wr_cyc, 1);
    chk("sw_rd_cyc", r_rd_cyc, 0);
    chk("sw_done_cyc", r_done_cyc, 2);
    chk("sw_mem", mem[12], 32'hCAFE_F00D);

    err_case("lw_41", 1'b0, 3'b010, 32'h41, 32'h0000_0001);
    err_case("sh_43", 1'b1, 3'b001, 32'h43, 32'h0000_0001);
    err_case("ld_f3_011", 1'b0, 3'b011, 32'h40, 32'h0000_0001);
    chk("err_mem_kept", mem[16], 32'h5566_7788);

    sel = 1'b1;
    mem_set(6'd9, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h25, 32'h0000_00AA);
    chk("sb3_rd_cyc", r_rd_cyc, 3);
    chk("sb3_wr_cyc", r_wr_cyc, 4);
    chk("sb3_done_cyc", r_done_cyc, 5);
    chk("sb3_mem", mem[9], 32'h1122_AA44);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw3_done_cyc", r_done_cyc, 4);
    chk("lw3_rdata", o_rdata, 32'hDEAD_BEEF);

    // Reset lands mid-cycle during the write cycle of an sb.
    sel = 1'b0;
    mem_set(6'd9, 32'h1122_3344);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h25; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rstwr_wr_before", {31'b0, o_mem_wr}, 1);
    rst = 1'b1;
    #1 chk("rstwr_wr_after", {31'b0, o_mem_wr}, 0);
    chk("rstwr_busy", {31'b0, o_busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("rstwr_no_done", ndone, 0);
    chk("rstwr_mem_kept", mem[9], 32'h1122_3344);

    // Second request arrives while busy and must be dropped.
    sel = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    req_funct3 = 3'b000; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    ndone = 0;
    seen_rdata = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_done) begin
        ndone++;
        seen_rdata = o_rdata;
      end
    end
    chk("busy_drop_ndone", ndone, 1);
    chk("busy_drop_rdata", seen_rdata, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
